i2c_write_master: RTL and testbench
===================================

Name: i2c_write_master

Overview:
- Clock-divided I2C master that issues single-byte write transactions: START, 7-bit address + W, data byte, STOP.
- Sits directly upstream of the address-translator top level and drives its scl/sda pins.
- Replaces bench-task stimulus with synthesizable RTL, so the translator can be exercised on hardware and in system-level simulation.
- Open-drain style: the block only ever pulls SDA low or releases it.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period; legal range ≥1. SCL period = 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only while busy=0
- addr  input  7  target slave address, latched on accept
- data  input  8  write data byte, latched on accept
- sda_i  input  1  resolved SDA line level, used for ACK sampling
- scl_o  output  1  SCL level (1 = released/high, 0 = driven low)
- sda_oe  output  1  1 = pull SDA low, 0 = release
- busy  output  1  high from the cycle after accept through the STOP condition
- done  output  1  one-cycle pulse at transaction end
- ack_err  output  1  set on any NACK; holds until the next accepted start

Behaviour:
- Reset (async, rst_n=0): scl_o=1, sda_oe=0, busy=0, done=0, ack_err=0; quarter counter=0; FSM enters IDLE. Asserting reset mid-transfer releases both lines immediately, with no STOP generated.
- Quarter tick: a counter of 0..CLK_DIV-1 advances only while busy=1. The tick fires when the count wraps. Every phase below lasts exactly one quarter.
- Accept: in IDLE with start=1, latch shreg={addr,1'b0}, latch data, clear ack_err, and set busy=1 on the next edge. A start seen while busy=1 is ignored and has no effect on latched values.
- FSM states: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- START (4 quarters):
  - Q0,Q1: scl_o=1, sda_oe=0.
  - Q2: scl_o=1, sda_oe=1 (START edge).
  - Q3: scl_o=0, sda_oe=1.
- Bit slot (ADDR, DATA, and both ACK states), 4 quarters:
  - Q0: scl_o=0; set sda_oe=~bit (MSB first).
  - Q1: scl_o=0.
  - Q2,Q3: scl_o=1.
  - SDA changes only while SCL is low.
- ADDR: 8 slots (7 address bits + W=0), then ADDR_ACK.
- ADDR_ACK:
  - sda_oe=0 for the whole slot.
  - sda_i is sampled on the tick ending Q2.
  - sda_i=0 → DATA.
  - sda_i=1 → ack_err=1 and go to STOP; the data byte is not sent.
- DATA: 8 slots, then DATA_ACK.
- DATA_ACK: sampled as in ADDR_ACK. NACK sets ack_err=1. Either result → STOP.
- STOP (4 quarters):
  - Q0: scl_o=0, sda_oe=1.
  - Q1,Q2: scl_o=1, sda_oe=1.
  - Q3: scl_o=1, sda_oe=0 (STOP edge).
- End of STOP: on the final tick, busy=0 and done=1 for one cycle; FSM returns to IDLE. A start asserted on the done cycle is accepted (back-to-back transactions are allowed).
- Latency from the accept edge to done:
  - Full transaction: 80 quarters = 80*CLK_DIV cycles.
  - Address NACK: 44 quarters = 44*CLK_DIV cycles.
- Bit counter: 3 bits, counts 7 down to 0. The transition happens on the tick ending Q3 of bit 0.

Test Plan:
- CLK_DIV=4, addr=0x50, data=0x3C, responder ACKs both → SDA sampled at SCL rising edges = 1010_0000 then 0011_1100; done pulses 320 cycles after accept; ack_err=0.
- addr=0x50 with no responder (sda_i held 1) → ack_err=1; done after 176 cycles; no SCL pulses between ADDR_ACK and STOP.
- Responder ACKs the address, NACKs data=0xA5 → data bits 1010_0101 transmitted; ack_err=1; STOP still generated; done at 320 cycles.
- start re-pulsed at cycle 50 of a transaction with addr=0x12 → ignored; waveform and latched addr/data unchanged; exactly one done.
- rst_n pulled low mid-DATA → same cycle scl_o=1, sda_oe=0, busy=0; after release, a new start with addr=0x50 completes normally.
- CLK_DIV=1, start held high continuously → back-to-back transactions every 81 cycles; START/STOP edge ordering verified by a protocol checker.

Source files
------------

// File: rtl/i2c_write_master.sv
// Single-byte I2C write master: START, 7-bit address + W, data byte, STOP.
// Open-drain SDA (pull low or release); SCL timed in quarters of CLK_DIV clocks.
module i2c_write_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t           state_q, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       quarter_q, quarter_nxt;
  logic [2:0]       bit_q, bit_nxt;
  logic [7:0]       shreg, data_q;
  logic             tick_c, accept_c;
  logic             scl_nxt, sda_nxt;

  assign tick_c   = busy && (div_cnt == DIV_MAX);
  assign accept_c = (state_q == S_IDLE) && start;

  // Quarter-period divider, free-running only during a transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (accept_c) begin
      div_cnt <= '0;
    end else if (busy) begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // State register; line levels are registered from the next phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      quarter_q <= 2'd0;
      bit_q     <= 3'd7;
      scl_o     <= 1'b1;
      sda_oe    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      quarter_q <= quarter_nxt;
      bit_q     <= bit_nxt;
      scl_o     <= scl_nxt;
      sda_oe    <= sda_nxt;
    end
  end

  // Next-state: phases advance on ticks, states change at the end of Q3
  always_comb begin
    state_nxt   = state_q;
    quarter_nxt = quarter_q;
    bit_nxt     = bit_q;
    if (accept_c) begin
      state_nxt   = S_START;
      quarter_nxt = 2'd0;
      bit_nxt     = 3'd7;
    end else if (tick_c) begin
      quarter_nxt = quarter_q + 2'd1;
      if (quarter_q == 2'd3) begin
        case (state_q)
          S_START:    state_nxt = S_ADDR;
          S_ADDR: begin
            bit_nxt = bit_q - 3'd1;
            if (bit_q == 3'd0) state_nxt = S_ADDR_ACK;
          end
          S_ADDR_ACK: state_nxt = ack_err ? S_STOP : S_DATA;
          S_DATA: begin
            bit_nxt = bit_q - 3'd1;
            if (bit_q == 3'd0) state_nxt = S_DATA_ACK;
          end
          S_DATA_ACK: state_nxt = S_STOP;
          S_STOP:     state_nxt = S_IDLE;
          default:    state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Line levels for the upcoming phase; SDA only moves with SCL low
  always_comb begin
    scl_nxt = 1'b1;
    sda_nxt = 1'b0;
    case (state_nxt)
      S_START: begin
        scl_nxt = (quarter_nxt != 2'd3);
        sda_nxt = quarter_nxt[1];
      end
      S_ADDR: begin
        scl_nxt = quarter_nxt[1];
        sda_nxt = ~shreg[bit_nxt];
      end
      S_DATA: begin
        scl_nxt = quarter_nxt[1];
        sda_nxt = ~data_q[bit_nxt];
      end
      S_ADDR_ACK, S_DATA_ACK: begin
        scl_nxt = quarter_nxt[1];
        sda_nxt = 1'b0;
      end
      S_STOP: begin
        scl_nxt = (quarter_nxt != 2'd0);
        sda_nxt = (quarter_nxt != 2'd3);
      end
      default: begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b0;
      end
    endcase
  end

  // Transaction status and latched payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      shreg   <= 8'd0;
      data_q  <= 8'd0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        busy    <= 1'b1;
        ack_err <= 1'b0;
        shreg   <= {addr, 1'b0};
        data_q  <= data;
      end else if (tick_c) begin
        if ((state_q == S_ADDR_ACK || state_q == S_DATA_ACK) &&
            quarter_q == 2'd2 && sda_i) begin
          ack_err <= 1'b1;
        end
        if (state_q == S_STOP && quarter_q == 2'd3) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus monitor with responder, protocol ordering and scoreboard.
module tb_i2c_write_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start, sda_i, scl_o, sda_oe, busy, done, ack_err;
  logic [6:0] addr [2];
  logic [7:0] data [2];
  logic [1:0] ack_addr, ack_data;

  always #5 clk = ~clk;

  i2c_write_master #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr[0]), .data(data[0]),
    .sda_i(sda_i[0]), .scl_o(scl_o[0]), .sda_oe(sda_oe[0]), .busy(busy[0]),
    .done(done[0]), .ack_err(ack_err[0]));

  i2c_write_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr[1]), .data(data[1]),
    .sda_i(sda_i[1]), .scl_o(scl_o[1]), .sda_oe(sda_oe[1]), .busy(busy[1]),
    .done(done[1]), .ack_err(ack_err[1]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    logic       chk_d;
    logic       err;
    int         lat;
    int         rises;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc [2];
  int   rises [2];
  int   falls [2];
  int   done_cnt [2];
  int   last_done [2];
  logic in_txn [2];
  logic prev_scl [2];
  logic prev_sda [2];
  logic [7:0] cap_a [2];
  logic [7:0] cap_d [2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Wired-AND bus with a responder that acknowledges in the 9th and 18th slots
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      sda_i[u] = ~(sda_oe[u] |
                   (in_txn[u] && ((falls[u] == 9 && ack_addr[u]) ||
                                  (falls[u] == 18 && ack_data[u]))));
    end
  end

  // Bus monitor and scoreboard, sampled on the inactive clock edge
  always @(negedge clk) begin : mon
    logic s, d;
    exp_t e;
    int   sz;
    for (int u = 0; u < 2; u++) begin
      s = scl_o[u];
      d = sda_i[u];
      if (!rst_n) begin
        in_txn[u]   = 1'b0;
        prev_scl[u] = 1'b1;
        prev_sda[u] = 1'b1;
      end else begin
        if (prev_scl[u] && s && prev_sda[u] && !d) begin
          check($sformatf("start_order%0d", u), int'(in_txn[u]), 0);
          in_txn[u] = 1'b1;
          rises[u]  = 0;
          falls[u]  = 0;
          cap_a[u]  = 8'd0;
          cap_d[u]  = 8'd0;
        end else if (prev_scl[u] && s && !prev_sda[u] && d) begin
          check($sformatf("stop_order%0d", u), int'(in_txn[u]), 1);
          in_txn[u] = 1'b0;
        end else if (!prev_scl[u] && s) begin
          rises[u]++;
          if (rises[u] >= 1 && rises[u] <= 8)   cap_a[u] = {cap_a[u][6:0], d};
          if (rises[u] >= 10 && rises[u] <= 17) cap_d[u] = {cap_d[u][6:0], d};
        end else if (prev_scl[u] && !s) begin
          falls[u]++;
        end
        if (done[u]) begin
          done_cnt[u]++;
          check($sformatf("stop_before_done%0d", u), int'(in_txn[u]), 0);
          if (u == 1 && last_done[1] >= 0)
            check("b2b_period", cyc - last_done[1], 81);
          last_done[u] = cyc;
          sz = (u == 0) ? sb0.size() : sb1.size();
          check($sformatf("sb_nonempty%0d", u), int'(sz != 0), 1);
          if (sz != 0) begin
            if (u == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            check($sformatf("latency%0d", u), cyc - acc_cyc[u], e.lat);
            check($sformatf("ack_err%0d", u), int'(ack_err[u]), int'(e.err));
            check($sformatf("addr_bits%0d", u), int'(cap_a[u]), int'(e.a));
            check($sformatf("scl_rises%0d", u), rises[u], e.rises);
            if (e.chk_d) check($sformatf("data_bits%0d", u), int'(cap_d[u]), int'(e.d));
          end
        end
        if (start[u] && !busy[u]) acc_cyc[u] = cyc + 1;
        prev_scl[u] = s;
        prev_sda[u] = d;
      end
    end
  end

  task automatic push_exp(input int u, input logic [6:0] a, input logic [7:0] d,
                          input logic aa, input logic ad);
    exp_t e;
    int   div;
    div     = (u == 0) ? 4 : 1;
    e.a     = {a, 1'b0};
    e.d     = d;
    e.chk_d = aa;
    e.err   = !aa || !ad;
    e.lat   = aa ? 80 * div : 44 * div;
    e.rises = aa ? 19 : 10;
    if (u == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic launch(input int u, input logic [6:0] a, input logic [7:0] d,
                        input logic aa, input logic ad);
    push_exp(u, a, d, aa, ad);
    ack_addr[u] = aa;
    ack_data[u] = ad;
    addr[u]     = a;
    data[u]     = d;
    start[u]    = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
  endtask

  task automatic wait_done(input int u, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done[u] && n < budget);
    if (!done[u]) check($sformatf("done_timeout%0d", u), int'(done[u]), 1);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 2'b00;
    ack_addr = 2'b00;
    ack_data = 2'b00;
    for (int u = 0; u < 2; u++) begin
      addr[u]      = 7'd0;
      data[u]      = 8'd0;
      rises[u]     = 0;
      falls[u]     = 0;
      done_cnt[u]  = 0;
      last_done[u] = -1;
      acc_cyc[u]   = 0;
      in_txn[u]    = 1'b0;
      prev_scl[u]  = 1'b1;
      prev_sda[u]  = 1'b1;
      cap_a[u]     = 8'd0;
      cap_d[u]     = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_scl%0d", u), int'(scl_o[u]), 1);
      check($sformatf("rst_sda_oe%0d", u), int'(sda_oe[u]), 0);
      check($sformatf("rst_busy%0d", u), int'(busy[u]), 0);
      check($sformatf("rst_done%0d", u), int'(done[u]), 0);
      check($sformatf("rst_ack_err%0d", u), int'(ack_err[u]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full write, both bytes acknowledged
    launch(0, 7'h50, 8'h3C, 1'b1, 1'b1);
    wait_done(0, 1000);
    repeat (3) @(posedge clk);
    #1;

    // No responder: address NACK, data never sent
    launch(0, 7'h50, 8'h3C, 1'b0, 1'b0);
    wait_done(0, 1000);
    repeat (10) @(posedge clk);
    #1;
    check("ack_err_hold", int'(ack_err[0]), 1);
    check("idle_after_nack", int'(busy[0]), 0);

    // Address acknowledged, data NACKed
    launch(0, 7'h50, 8'hA5, 1'b1, 1'b0);
    wait_done(0, 1000);
    repeat (3) @(posedge clk);
    #1;

    // Start re-pulsed mid-transfer with different payload is ignored
    launch(0, 7'h12, 8'h99, 1'b1, 1'b1);
    repeat (48) @(posedge clk);
    #1;
    check("busy_mid", int'(busy[0]), 1);
    addr[0]  = 7'h7F;
    data[0]  = 8'h00;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 1000);
    repeat (400) @(posedge clk);
    #1;
    check("single_done", done_cnt[0], 4);

    // Reset asserted in the data phase drops both lines at once
    launch(0, 7'h50, 8'h3C, 1'b1, 1'b1);
    repeat (200) @(posedge clk);
    #2;
    check("busy_pre_rst", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_scl", int'(scl_o[0]), 1);
    check("rst_mid_sda_oe", int'(sda_oe[0]), 0);
    check("rst_mid_busy", int'(busy[0]), 0);
    void'(sb0.pop_back());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    launch(0, 7'h50, 8'h3C, 1'b1, 1'b1);
    wait_done(0, 1000);
    repeat (3) @(posedge clk);
    #1;
    check("done_count0", done_cnt[0], 5);

    // CLK_DIV=1 with start held high: back-to-back transactions
    ack_addr[1] = 1'b1;
    ack_data[1] = 1'b1;
    addr[1]     = 7'h50;
    data[1]     = 8'h3C;
    for (int i = 0; i < 3; i++) push_exp(1, 7'h50, 8'h3C, 1'b1, 1'b1);
    start[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 400 && n < 3; i++) begin
      @(posedge clk);
      #1;
      if (done[1]) n++;
    end
    start[1] = 1'b0;
    check("b2b_dones_seen", n, 3);
    repeat (100) @(posedge clk);
    #1;
    check("done_count1", done_cnt[1], 3);
    check("busy1_idle", int'(busy[1]), 0);
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
